// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encoding, FSM states and slice op select
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SOP_AND = 3'd0,
    SOP_OR  = 3'd1,
    SOP_XOR = 3'd2,
    SOP_ADD = 3'd3,
    SOP_SUB = 3'd4
  } slice_op_t;

  function automatic logic is_legal_ctrl(input logic [3:0] c);
    return (c == ALU_AND) || (c == ALU_OR) || (c == ALU_ADD) || (c == ALU_XOR) ||
           (c == ALU_SUB) || (c == ALU_SLT) || (c == ALU_SLTU);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice with explicit carry-in
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      cin,
  input  slice_op_t op,
  output logic      res,
  output logic      cout
);

  logic b_eff;

  always_comb begin
    res   = 1'b0;
    cout  = 1'b0;
    b_eff = (op == SOP_SUB) ? ~b : b;
    case (op)
      SOP_AND: res = a & b;
      SOP_OR:  res = a | b;
      SOP_XOR: res = a ^ b;
      SOP_ADD, SOP_SUB: begin
        res  = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: begin
        res  = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial ALU sequencer, one slice evaluation per cycle LSB first
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  slice_op_t s_op;
  logic      s_res, s_cout;
  logic      msb_ovf, set_bit;

  always_comb begin
    case (ctrl_q)
      ALU_AND: s_op = SOP_AND;
      ALU_OR:  s_op = SOP_OR;
      ALU_XOR: s_op = SOP_XOR;
      ALU_ADD: s_op = SOP_ADD;
      default: s_op = SOP_SUB;
    endcase
  end

  alu_bit_slice u_slice (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (cy_q),
    .op   (s_op),
    .res  (s_res),
    .cout (s_cout)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    sh_d      = sh_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    msb_ovf   = cy_q ^ s_cout;
    set_bit   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_legal_ctrl(ctrl)) begin
            a_d       = a;
            b_d       = b;
            ctrl_d    = ctrl;
            cnt_d     = '0;
            cy_d      = (ctrl == ALU_SUB) || (ctrl == ALU_SLT) || (ctrl == ALU_SLTU);
            illegal_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            result_d  = '0;
            carry_d   = 1'b0;
            ovf_d     = 1'b0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        cy_d  = s_cout;
        cnt_d = cnt_q + CW'(1);
        // Shift register is one bit short: the MSB comes straight from the slice.
        if ((ctrl_q != ALU_SLT) && (ctrl_q != ALU_SLTU))
          sh_d = (WIDTH-1)'({s_res, sh_q} >> 1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          if ((ctrl_q == ALU_SLT) || (ctrl_q == ALU_SLTU)) begin
            set_bit  = (ctrl_q == ALU_SLT) ? (s_res ^ msb_ovf) : ~s_cout;
            result_d = {{(WIDTH-1){1'b0}}, set_bit};
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
          end else begin
            result_d = {s_res, sh_q};
            carry_d  = (ctrl_q == ALU_ADD) || (ctrl_q == ALU_SUB) ? s_cout : 1'b0;
            ovf_d    = (ctrl_q == ALU_ADD) || (ctrl_q == ALU_SUB) ? msb_ovf : 1'b0;
          end
          zero_d = (result_d == '0);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= ALU_AND;
      sh_q      <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cy_q      <= cy_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      sh_q      <= sh_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed and randomized checks of alu_serial_seq against an arithmetic model
module tb_alu_serial_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ctrl = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out, overflow, zero, illegal;
  logic [W-1:0] result;

  int n_pass = 0;
  int n_total = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ctrl      (ctrl),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic co, output logic ov, output logic il);
    logic [W:0] s;
    r = '0; co = 1'b0; ov = 1'b0; il = 1'b0;
    case (c)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd3: r = x ^ y;
      4'd2: begin
        s  = {1'b0, x} + {1'b0, y};
        r  = s[W-1:0];
        co = s[W];
        ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd10: begin
        s  = {1'b0, x} + {1'b0, ~y} + 1;
        r  = s[W-1:0];
        co = s[W];
        ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'd11: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd12: r = (x < y) ? 1 : 0;
      default: il = 1'b1;
    endcase
  endtask

  // Called in the cycle after the previous done (or any idle cycle); returns in the cycle after done.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] er;
    logic eco, eov, eil;
    int cyc;
    bit busy_bad;
    model(c, x, y, er, eco, eov, eil);
    start = 1'b1; ctrl = c; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; ctrl = 4'($urandom);
    cyc = 0; busy_bad = 0;
    while (!done && cyc < 50) begin
      if (!busy) busy_bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, W'(cyc), eil ? W'(0) : W'(W));
    chk({tag, ".busy_run"}, W'(busy_bad), W'(0));
    chk({tag, ".busy_done"}, W'(busy), W'(1));
    chk({tag, ".result"}, result, er);
    chk({tag, ".carry"}, W'(carry_out), W'(eco));
    chk({tag, ".ovf"}, W'(overflow), W'(eov));
    chk({tag, ".zero"}, W'(zero), W'(er == '0));
    chk({tag, ".illegal"}, W'(illegal), W'(eil));
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, W'(done), W'(0));
    chk({tag, ".idle"}, W'(busy), W'(0));
    chk({tag, ".hold"}, result, er);
  endtask

  logic [3:0] ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd10, 4'd11, 4'd12, 4'd5, 4'd15};
  logic [W-1:0] edge_vals [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.done", W'(done), W'(0));
    chk("rst.result", result, W'(0));
    chk("rst.flags", W'({carry_out, overflow, zero, illegal}), W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h1);
    run_op("sub_ovf", 4'd10, 32'h8000_0000, 32'h1);
    run_op("sub_borrow", 4'd10, 32'h1, 32'h2);
    run_op("slt", 4'd11, 32'hFFFF_FFFF, 32'h1);
    run_op("sltu", 4'd12, 32'hFFFF_FFFF, 32'h1);
    run_op("and", 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op("or", 4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op("xor", 4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_op("illegal5", 4'd5, 32'h1234, 32'h5678);
    run_op("add_after_ill", 4'd2, 32'd3, 32'd4);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x, y;
      x = (i % 4 == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      y = (i % 3 == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      if (i % 5 == 0) y = x;
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 8)], x, y);
    end

    // Reset mid-operation, with an ignored start in between.
    start = 1'b1; ctrl = 4'd2; a = 32'h1234_5678; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; ctrl = 4'd5; a = 32'hDEAD_BEEF; b = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign.busy", W'(busy), W'(1));
    chk("ign.illegal", W'(illegal), W'(0));
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.busy", W'(busy), W'(0));
    chk("mid_rst.done", W'(done), W'(0));
    chk("mid_rst.result", result, W'(0));
    chk("mid_rst.flags", W'({carry_out, overflow, zero, illegal}), W'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst.no_done", W'(done), W'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("add_post_rst", 4'd2, 32'h1234_5678, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
